// File: rtl/sdram_mem_tester.sv
// sdram_mem_tester: writes a seeded address-derived pattern to a word range, then reads it back and compares.
// Latency: each word costs one request (held until ack) plus one gap cycle per phase; results are valid when odone=1.
// Backpressure: every request is held until the controller acks it; after ACK_TIMEOUT unacked cycles the test aborts.
module sdram_mem_tester #(
   parameter int ADDR_W      = 22,
   parameter int DATA_W      = 16,
   parameter int ACK_TIMEOUT = 1023
) (
   input  logic              iclk,
   input  logic              ireset,
   input  logic              istart,
   input  logic [ADDR_W-1:0] ibase_address,
   input  logic [ADDR_W-1:0] ilength,
   input  logic [DATA_W-1:0] iseed,
   output logic              owrite_req,
   output logic [ADDR_W-1:0] owrite_address,
   output logic [DATA_W-1:0] owrite_data,
   input  logic              iwrite_ack,
   output logic              oread_req,
   output logic [ADDR_W-1:0] oread_address,
   input  logic [DATA_W-1:0] iread_data,
   input  logic              iread_ack,
   output logic              obusy,
   output logic              odone,
   output logic              opass,
   output logic              otimeout,
   output logic [15:0]       oerror_count,
   output logic [ADDR_W-1:0] ofirst_err_address
);

   localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] first_err_q, first_err_d;
   logic [DATA_W-1:0] seed_q, seed_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [15:0]       err_cnt_q, err_cnt_d;
   logic              wr_req_q, wr_req_d;
   logic              rd_req_q, rd_req_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              timeout_q, timeout_d;

   logic [ADDR_W-1:0] idx_inc;
   logic [ADDR_W-1:0] next_addr;
   logic              last_word;
   logic              tmo_hit;

   // Test pattern: low 16 address bits XOR the seed.
   function automatic logic [DATA_W-1:0] pattern(input logic [15:0] a16, input logic [DATA_W-1:0] s);
      return DATA_W'(a16) ^ s;
   endfunction

   // Shared helpers: next index/address (wrapping at 2^ADDR_W), end-of-range and ack-timeout detection.
   always_comb begin
      idx_inc   = idx_q + ADDR_W'(1);
      next_addr = base_q + idx_inc;
      last_word = (idx_inc == len_q);
      tmo_hit   = ((tmo_q + TMO_W'(1)) == TMO_W'(ACK_TIMEOUT));
   end

   // Next-state and registered-output computation for the test sequencer.
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      len_d       = len_q;
      idx_d       = idx_q;
      addr_d      = addr_q;
      first_err_d = first_err_q;
      seed_d      = seed_q;
      data_d      = data_q;
      tmo_d       = tmo_q;
      err_cnt_d   = err_cnt_q;
      wr_req_d    = wr_req_q;
      rd_req_d    = rd_req_q;
      busy_d      = busy_q;
      done_d      = done_q;
      pass_d      = pass_q;
      timeout_d   = timeout_q;

      case (state_q)
         IDLE, DONE: begin
            if (istart) begin
               base_d      = ibase_address;
               len_d       = ilength;
               seed_d      = iseed;
               idx_d       = '0;
               addr_d      = ibase_address;
               data_d      = pattern(ibase_address[15:0], iseed);
               tmo_d       = '0;
               err_cnt_d   = '0;
               first_err_d = '0;
               timeout_d   = 1'b0;
               if (ilength == '0) begin
                  // Empty range: nothing to test, report a pass immediately.
                  state_d = DONE;
                  done_d  = 1'b1;
                  pass_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d  = WR_REQ;
                  wr_req_d = 1'b1;
                  done_d   = 1'b0;
                  pass_d   = 1'b0;
                  busy_d   = 1'b1;
               end
            end
         end
         WR_REQ: begin
            if (iwrite_ack) begin
               wr_req_d = 1'b0;
               state_d  = WR_GAP;
            end else if (tmo_hit) begin
               wr_req_d  = 1'b0;
               timeout_d = 1'b1;
               done_d    = 1'b1;
               pass_d    = 1'b0;
               busy_d    = 1'b0;
               state_d   = DONE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         WR_GAP: begin
            tmo_d = '0;
            if (last_word) begin
               idx_d    = '0;
               addr_d   = base_q;
               rd_req_d = 1'b1;
               state_d  = RD_REQ;
            end else begin
               idx_d    = idx_inc;
               addr_d   = next_addr;
               data_d   = pattern(next_addr[15:0], seed_q);
               wr_req_d = 1'b1;
               state_d  = WR_REQ;
            end
         end
         RD_REQ: begin
            if (iread_ack) begin
               rd_req_d = 1'b0;
               state_d  = RD_GAP;
               if (iread_data != pattern(addr_q[15:0], seed_q)) begin
                  if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                  // A zero count means no earlier mismatch has been recorded.
                  if (err_cnt_q == 16'd0) first_err_d = addr_q;
               end
            end else if (tmo_hit) begin
               rd_req_d  = 1'b0;
               timeout_d = 1'b1;
               done_d    = 1'b1;
               pass_d    = 1'b0;
               busy_d    = 1'b0;
               state_d   = DONE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         RD_GAP: begin
            tmo_d = '0;
            if (last_word) begin
               idx_d   = '0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               pass_d  = (err_cnt_q == 16'd0) && !timeout_q;
               state_d = DONE;
            end else begin
               idx_d    = idx_inc;
               addr_d   = next_addr;
               rd_req_d = 1'b1;
               state_d  = RD_REQ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset clears everything without waiting for a clock.
   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         state_q     <= IDLE;
         base_q      <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         addr_q      <= '0;
         first_err_q <= '0;
         seed_q      <= '0;
         data_q      <= '0;
         tmo_q       <= '0;
         err_cnt_q   <= '0;
         wr_req_q    <= 1'b0;
         rd_req_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         addr_q      <= addr_d;
         first_err_q <= first_err_d;
         seed_q      <= seed_d;
         data_q      <= data_d;
         tmo_q       <= tmo_d;
         err_cnt_q   <= err_cnt_d;
         wr_req_q    <= wr_req_d;
         rd_req_q    <= rd_req_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         timeout_q   <= timeout_d;
      end
   end

   assign owrite_req         = wr_req_q;
   assign owrite_address     = addr_q;
   assign owrite_data        = data_q;
   assign oread_req          = rd_req_q;
   assign oread_address      = addr_q;
   assign obusy              = busy_q;
   assign odone              = done_q;
   assign opass              = pass_q;
   assign otimeout           = timeout_q;
   assign oerror_count       = err_cnt_q;
   assign ofirst_err_address = first_err_q;

endmodule

// File: doc/sdram_mem_tester.md
SDRAM_MEM_TESTER -- requirements
Module: sdram_mem_tester

Interface
REQ-001 Parameter: ADDR_W, 22, word-address width shared with the SDRAM controller.
REQ-002 Parameter: DATA_W, 16, data width shared with the SDRAM controller.
REQ-003 Parameter: ACK_TIMEOUT, 1023, maximum cycles to wait for an ack before aborting.
REQ-004 Port: iclk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port: ireset  input  1  asynchronous, active-high reset.
REQ-006 Port: istart  input  1  start a test; sampled only in IDLE or DONE.
REQ-007 Port: ibase_address  input  ADDR_W  first word address; latched on accepted start.
REQ-008 Port: ilength  input  ADDR_W  number of words to test; latched on accepted start.
REQ-009 Port: iseed  input  DATA_W  pattern seed; latched on accepted start.
REQ-010 Port: owrite_req / owrite_address / owrite_data  output  1/ADDR_W/DATA_W  write request to the controller.
REQ-011 Port: iwrite_ack  input  1  controller write acknowledge.
REQ-012 Port: oread_req / oread_address  output  1/ADDR_W  read request to the controller.
REQ-013 Port: iread_data / iread_ack  input  DATA_W/1  read data, valid in the ack cycle.
REQ-014 Port: obusy / odone / opass / otimeout  output  1 each  status flags.
REQ-015 Port: oerror_count / ofirst_err_address  output  16/ADDR_W  mismatch count and first failing address.

Function
REQ-016 States: IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE.
REQ-017 Accepted start: istart=1 in IDLE or DONE; latch inputs; clear all status; index i=0; go to WR_REQ. If ilength=0, go directly to DONE with opass=1.
REQ-018 Address = (base + i) mod 2^ADDR_W (wraps past the top). Pattern = address[15:0] XOR seed.
REQ-019 WR_REQ: owrite_req=1 with address and data registered and stable; stay until iwrite_ack=1, then WR_GAP.
REQ-020 WR_GAP: exactly one cycle with owrite_req=0; i+1; if i+1=length, i=0 and go to RD_REQ; else WR_REQ.
REQ-021 RD_REQ: oread_req=1, address stable; in the cycle iread_ack=1, compare iread_data to pattern, then RD_GAP.
REQ-022 RD_GAP: one cycle with oread_req=0; i+1; last word goes to DONE; otherwise RD_REQ.
REQ-023 Mismatch: oerror_count increments, saturating at 16'hFFFF. ofirst_err_address captures only the first mismatch.
REQ-024 Acks received in any state other than the matching REQ state are ignored. A held-high ack counts once.
REQ-025 owrite_req and oread_req are never high simultaneously.
REQ-026 Timeout counter resets on entry to each REQ state. When it reaches ACK_TIMEOUT: set otimeout=1, drop req, go to DONE, opass=0.
REQ-027 DONE: odone=1, obusy=0; opass=1 iff oerror_count=0 and otimeout=0; results hold until the next accepted start.
REQ-028 obusy=1 in every state except IDLE and DONE. istart while busy is ignored.

Reset
REQ-029 ireset=1 forces, without waiting for a clock: state IDLE, all requests 0, addresses/data 0, obusy=odone=opass=otimeout=0, oerror_count=0, ofirst_err_address=0.
REQ-030 Reset mid-test abandons the test immediately; the next accepted start restarts from i=0.

Verification
REQ-031 base=0, length=4, seed=16'h0013, ideal model (ack 2 cycles after req) -> writes 0..3 with data 0013,0012,0011,0010; 4 reads; odone=1, opass=1, oerror_count=0.
REQ-032 Same as REQ-031 with the model corrupting the read at address 2 -> oerror_count=1, ofirst_err_address=2, opass=0.
REQ-033 base=22'h3FFFFE, length=4 -> addresses 3FFFFE, 3FFFFF, 000000, 000001 in both phases.
REQ-034 Model never acks the first write, ACK_TIMEOUT=16 -> owrite_req drops after 16 cycles; otimeout=1, odone=1, opass=0.
REQ-035 Assert ireset during the third read, then start again with length=2 -> all outputs zero during reset; clean 2-word pass afterwards.
REQ-036 ilength=0 -> DONE next cycle with opass=1 and no requests issued; istart pulsed mid-test -> ignored and results unaffected.
